// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the pipeline writeback
// stage and a multicycle unit (mul/div). A multicycle result is captured into
// a one-entry hold buffer and written when the pipeline leaves the port idle,
// or after it has lost STARVE_LIMIT consecutive cycles. Then the pipeline is
// stalled for one cycle.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   pipe_valid/pipe_rd/pipe_data   writeback-stage write request
//   pipe_stall                     writeback request not consumed this cycle
//   mc_valid/mc_rd/mc_data         multicycle result offer
//   mc_ready                       hold buffer empty, can accept
//   flush                          mispredict kill of the held result
//   rf_we/rf_rd/rf_data            registered regfile write port
//   mc_pend/mc_pend_rd             hold buffer occupancy for decode interlock
//
// state | meaning
// EMPTY | hold buffer invalid, pipeline owns the port, mc_ready high
// HELD  | hold buffer valid, arbitrating against the pipeline

module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        mc_valid,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    input  logic        flush,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_data,
    output logic        mc_pend,
    output logic [4:0]  mc_pend_rd
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  hold_rd_q, hold_rd_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic [3:0]  wait_q, wait_d;

    logic        held;
    logic        starved;
    logic        buf_win;
    logic        pipe_win;
    logic        wr_go;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;

    assign held    = (state_q == HELD);
    assign starved = (wait_q == LIMIT);
    // A flush kills the held result before it can win the port.
    assign buf_win  = held && !flush && (!pipe_valid || starved);
    assign pipe_win = pipe_valid && !buf_win;

    assign wr_go   = buf_win || pipe_win;
    assign wr_rd   = buf_win ? hold_rd_q   : pipe_rd;
    assign wr_data = buf_win ? hold_data_q : pipe_data;

    always_comb begin
        state_d     = state_q;
        hold_rd_d   = hold_rd_q;
        hold_data_d = hold_data_q;
        wait_d      = wait_q;
        case (state_q)
            EMPTY: begin
                if (mc_valid && !flush) begin
                    state_d     = HELD;
                    hold_rd_d   = mc_rd;
                    hold_data_d = mc_data;
                    wait_d      = 4'd0;
                end
            end
            HELD: begin
                if (flush || buf_win) begin
                    state_d = EMPTY;
                    wait_d  = 4'd0;
                end else if (pipe_rd == hold_rd_q && hold_rd_q != 5'd0) begin
                    // Younger pipeline write to the same rd makes the held
                    // result dead; drop it instead of overwriting later.
                    state_d = EMPTY;
                    wait_d  = 4'd0;
                end else if (!starved) begin
                    wait_d = wait_q + 4'd1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            hold_rd_q   <= 5'd0;
            hold_data_q <= 32'd0;
            wait_q      <= 4'd0;
            rf_we       <= 1'b0;
            rf_rd       <= 5'd0;
            rf_data     <= 32'd0;
        end else begin
            state_q     <= state_d;
            hold_rd_q   <= hold_rd_d;
            hold_data_q <= hold_data_d;
            wait_q      <= wait_d;
            rf_we       <= wr_go && (wr_rd != 5'd0);
            if (wr_go) begin
                rf_rd   <= wr_rd;
                rf_data <= wr_data;
            end
        end
    end

    assign mc_ready   = !held;
    assign pipe_stall = pipe_valid && buf_win;
    assign mc_pend    = held;
    assign mc_pend_rd = held ? hold_rd_q : 5'd0;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
// Scoreboard bench: each cycle the reference model predicts the registered
// write port, pushes it to a queue, and the entry is popped and compared one
// edge later. Combinational outputs are compared against the model before
// each edge.

module tb_wb_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_rd = 5'd0;
    logic [31:0] pipe_data = 32'd0;
    logic        pipe_stall;
    logic        mc_valid = 1'b0;
    logic [4:0]  mc_rd = 5'd0;
    logic [31:0] mc_data = 32'd0;
    logic        mc_ready;
    logic        flush = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        mc_pend;
    logic [4:0]  mc_pend_rd;

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .pipe_stall (pipe_stall),
        .mc_valid   (mc_valid),
        .mc_rd      (mc_rd),
        .mc_data    (mc_data),
        .mc_ready   (mc_ready),
        .flush      (flush),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_data    (rf_data),
        .mc_pend    (mc_pend),
        .mc_pend_rd (mc_pend_rd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic        m_held = 1'b0;
    logic [4:0]  m_rd = 5'd0;
    logic [31:0] m_data = 32'd0;
    int          m_cnt = 0;
    logic [4:0]  m_rf_rd = 5'd0;
    logic [31:0] m_rf_data = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic fl, input logic r);
        logic starve, bwin, pwin, was_held;
        wr_t  e;
        wr_t  got;
        pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
        mc_valid = mv; mc_rd = mrd; mc_data = md;
        flush = fl; rst = r;
        #1;
        e.we = 1'b0; e.rd = m_rf_rd; e.data = m_rf_data;
        if (r) begin
            m_held = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_cnt = 0;
            m_rf_rd = 5'd0; m_rf_data = 32'd0;
            e = '0;
        end else begin
            was_held = m_held;
            starve = m_held && (m_cnt == LIMIT);
            bwin = m_held && !fl && (!pv || starve);
            pwin = pv && !bwin;
            chk("mc_ready", {31'd0, mc_ready}, {31'd0, !m_held});
            chk("mc_pend", {31'd0, mc_pend}, {31'd0, m_held});
            chk("mc_pend_rd", {27'd0, mc_pend_rd}, {27'd0, (m_held ? m_rd : 5'd0)});
            chk("pipe_stall", {31'd0, pipe_stall}, {31'd0, (m_held && pv && starve && !fl)});
            if (bwin) begin
                e.we = (m_rd != 5'd0); e.rd = m_rd; e.data = m_data;
                m_held = 1'b0; m_cnt = 0;
            end else if (pwin) begin
                e.we = (prd != 5'd0); e.rd = prd; e.data = pd;
                if (m_held) begin
                    if (fl || (prd == m_rd && m_rd != 5'd0)) begin
                        m_held = 1'b0; m_cnt = 0;
                    end else if (m_cnt < LIMIT) begin
                        m_cnt++;
                    end
                end
            end else if (m_held && fl) begin
                m_held = 1'b0; m_cnt = 0;
            end
            if (!was_held && mv && !fl) begin
                m_held = 1'b1; m_rd = mrd; m_data = md; m_cnt = 0;
            end
            m_rf_rd = e.rd; m_rf_data = e.data;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            chk("rf_we", {31'd0, rf_we}, {31'd0, got.we});
            chk("rf_rd", {27'd0, rf_rd}, {27'd0, got.rd});
            chk("rf_data", rf_data, got.data);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0);
    endtask

    initial begin
        // reset
        @(negedge clk);
        step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 1);
        step(1, 5'd3, 32'h1111, 1, 5'd2, 32'h2222, 0, 1);
        idle(1);

        // pipe only
        step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 0);
        idle(1);

        // multicycle alone
        step(0, 5'd0, 32'd0, 1, 5'd7, 32'h12345678, 0, 0);
        idle(3);

        // starvation
        step(0, 5'd0, 32'd0, 1, 5'd9, 32'h99999999, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 5'd10 + 5'(i), 32'h100 + i, 0, 5'd0, 32'd0, 0, 0);
        idle(1);

        // WAW kill
        step(1, 5'd1, 32'h1, 1, 5'd3, 32'h33333333, 0, 0);
        step(1, 5'd3, 32'hA, 0, 5'd0, 32'd0, 0, 0);
        idle(3);

        // flush in HELD, pipe granted in the same cycle
        step(1, 5'd2, 32'h2, 1, 5'd4, 32'h44444444, 0, 0);
        step(1, 5'd6, 32'h6, 0, 5'd0, 32'd0, 1, 0);
        idle(2);

        // flush in EMPTY discards the offer
        step(0, 5'd0, 32'd0, 1, 5'd8, 32'h88888888, 1, 0);
        idle(2);

        // reset while holding
        step(1, 5'd2, 32'h22, 1, 5'd4, 32'h44440000, 0, 0);
        step(1, 5'd6, 32'h66, 1, 5'd5, 32'h55, 0, 1);
        idle(3);

        // rd = 0 cases
        step(1, 5'd0, 32'hCAFE, 0, 5'd0, 32'd0, 0, 0);
        step(0, 5'd0, 32'd0, 1, 5'd0, 32'hF00D, 0, 0);
        idle(2);

        // back-to-back offers with continuous mc_valid
        for (int i = 0; i < 6; i++) step(0, 5'd0, 32'd0, 1, 5'd12 + 5'(i), 32'hB00 + i, 0, 0);
        idle(1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule
